// File: rtl/reg_op_sequencer.sv
// Register-to-register ALU operation sequencer: steps Y load, ALU op, LO and HI
// writeback, one state per cycle, and drives one-hot register bus enables.
module reg_op_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = 5
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [OP_W-1:0]     opcode,
    input  logic [IDX_W-1:0]    ra,
    input  logic [IDX_W-1:0]    rb,
    input  logic [IDX_W-1:0]    rc,
    input  logic                unary,
    input  logic                wide,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [OP_W-1:0]     op,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] T_Y  = 3'd1;
    localparam logic [2:0] T_OP = 3'd2;
    localparam logic [2:0] T_LO = 3'd3;
    localparam logic [2:0] T_HI = 3'd4;

    localparam logic [31:0]         REG_LIMIT = NUM_REGS;
    localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);

    logic [2:0]       state;
    logic [OP_W-1:0]  opcode_q;
    logic [IDX_W-1:0] ra_q;
    logic [IDX_W-1:0] rb_q;
    logic [IDX_W-1:0] rc_q;
    logic             wide_q;
    logic             idx_bad;

    // ra is never written back on a wide operation, so it cannot make the request illegal
    assign idx_bad = (32'(rb) >= REG_LIMIT) || (32'(rc) >= REG_LIMIT) ||
                     (!wide && (32'(ra) >= REG_LIMIT));

    always_ff @(posedge Clock) begin
        if (clear) begin
            state    <= IDLE;
            err      <= 1'b0;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            wide_q   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (idx_bad) begin
                            err <= 1'b1;
                        end else begin
                            opcode_q <= opcode;
                            ra_q     <= ra;
                            rb_q     <= rb;
                            rc_q     <= rc;
                            wide_q   <= wide;
                            state    <= unary ? T_OP : T_Y;
                        end
                    end
                end
                T_Y:     state <= T_OP;
                T_OP:    state <= T_LO;
                T_LO:    state <= wide_q ? T_HI : IDLE;
                T_HI:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded only from flopped state and captured fields, never from live inputs
    always_comb begin
        busy     = (state != IDLE);
        done     = 1'b0;
        op       = '0;
        reg_out  = '0;
        reg_in   = '0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        case (state)
            T_Y: begin
                reg_out = ONE_HOT0 << rb_q;
                Yin     = 1'b1;
            end
            T_OP: begin
                reg_out = ONE_HOT0 << rc_q;
                Zin     = 1'b1;
                op      = opcode_q;
            end
            T_LO: begin
                Zlowout = 1'b1;
                done    = !wide_q;
                if (wide_q) begin
                    LOin = 1'b1;
                end else begin
                    reg_in = ONE_HOT0 << ra_q;
                end
            end
            T_HI: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: a queue of expected per-cycle strobe
// patterns plus a tiny register/ALU datapath, with directed and random steps.
module tb_reg_op_sequencer;

    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;
    localparam int OP_W     = 5;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                yin;
        logic                zin;
        logic                zlo;
        logic                zhi;
        logic                loin;
        logic                hiin;
        logic [OP_W-1:0]     op;
        logic [NUM_REGS-1:0] reg_out;
        logic [NUM_REGS-1:0] reg_in;
    } outs_t;

    logic                Clock = 1'b0;
    logic                clear = 1'b1;
    logic                start = 1'b0;
    logic                unary = 1'b0;
    logic                wide  = 1'b0;
    logic [OP_W-1:0]     opcode = '0;
    logic [IDX_W-1:0]    ra = '0;
    logic [IDX_W-1:0]    rb = '0;
    logic [IDX_W-1:0]    rc = '0;
    logic                busy, done, err, Yin, Zin, Zlowout, Zhighout, LOin, HIin;
    logic [OP_W-1:0]     op;
    logic [NUM_REGS-1:0] reg_out, reg_in;

    logic                start8 = 1'b0;
    logic                unary8 = 1'b0;
    logic                wide8  = 1'b0;
    logic [IDX_W-1:0]    ra8 = '0;
    logic [IDX_W-1:0]    rb8 = '0;
    logic [IDX_W-1:0]    rc8 = '0;
    logic                busy8, done8, err8, Yin8, Zin8, Zlowout8, Zhighout8, LOin8, HIin8;
    logic [OP_W-1:0]     op8;
    logic [7:0]          reg_out8, reg_in8;

    outs_t       exp_q[$];
    logic        err_exp = 1'b0;
    int          n_asserts = 0;
    int          n_fail = 0;
    logic        preload = 1'b0;

    logic [31:0] rf [NUM_REGS];
    logic [31:0] y_reg;
    logic [63:0] z_reg;
    logic [31:0] bus;

    always #5 Clock = ~Clock;

    reg_op_sequencer #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .OP_W(OP_W)) dut (
        .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .unary(unary), .wide(wide),
        .busy(busy), .done(done), .err(err), .op(op),
        .reg_out(reg_out), .reg_in(reg_in),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .LOin(LOin), .HIin(HIin)
    );

    reg_op_sequencer #(.NUM_REGS(8), .IDX_W(4), .OP_W(OP_W)) dut8 (
        .Clock(Clock), .clear(clear), .start(start8), .opcode(opcode),
        .ra(ra8), .rb(rb8), .rc(rc8), .unary(unary8), .wide(wide8),
        .busy(busy8), .done(done8), .err(err8), .op(op8),
        .reg_out(reg_out8), .reg_in(reg_in8),
        .Yin(Yin8), .Zin(Zin8), .Zlowout(Zlowout8), .Zhighout(Zhighout8),
        .LOin(LOin8), .HIin(HIin8)
    );

    // Toy datapath: opcode 3 is a left shift, anything else adds
    always_comb begin
        bus = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (reg_out[i]) bus = rf[i];
        if (Zlowout)  bus = z_reg[31:0];
        if (Zhighout) bus = z_reg[63:32];
    end

    always @(posedge Clock) begin
        if (preload) begin
            rf[3] <= 32'd12;
            rf[2] <= 32'd5;
            rf[1] <= 32'd0;
        end else begin
            if (Yin) y_reg <= bus;
            if (Zin) z_reg <= (op == 5'b00011) ? {32'b0, y_reg << bus[4:0]} : {32'b0, y_reg + bus};
            for (int i = 0; i < NUM_REGS; i++)
                if (reg_in[i]) rf[i] <= bus;
        end
    end

    task automatic pushSequence(input logic [OP_W-1:0] opc, input logic [IDX_W-1:0] a, b, c,
                                input logic un, wd);
        outs_t s;
        if (!un) begin
            s = '0; s.busy = 1'b1; s.yin = 1'b1; s.reg_out = NUM_REGS'(1) << b;
            exp_q.push_back(s);
        end
        s = '0; s.busy = 1'b1; s.zin = 1'b1; s.op = opc; s.reg_out = NUM_REGS'(1) << c;
        exp_q.push_back(s);
        s = '0; s.busy = 1'b1; s.zlo = 1'b1;
        if (wd) s.loin = 1'b1;
        else begin
            s.reg_in = NUM_REGS'(1) << a;
            s.done = 1'b1;
        end
        exp_q.push_back(s);
        if (wd) begin
            s = '0; s.busy = 1'b1; s.zhi = 1'b1; s.hiin = 1'b1; s.done = 1'b1;
            exp_q.push_back(s);
        end
    endtask

    task automatic applyStimulus(input logic cl, st, un, wd, input logic [OP_W-1:0] opc,
                                 input logic [IDX_W-1:0] a, b, c);
        bit was_idle;
        clear = cl; start = st; unary = un; wide = wd; opcode = opc; ra = a; rb = b; rc = c;
        was_idle = (exp_q.size() == 0);
        if (!was_idle) exp_q.delete(0);
        err_exp = 1'b0;
        if (cl) exp_q.delete();
        else if (was_idle && st) pushSequence(opc, a, b, c, un, wd);
        @(negedge Clock);
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      OP_W'($urandom), IDX_W'($urandom), IDX_W'($urandom), IDX_W'($urandom));
    endtask

    task automatic checkOutput(input string tag);
        outs_t obs, e;
        obs = {busy, done, Yin, Zin, Zlowout, Zhighout, LOin, HIin, op, reg_out, reg_in};
        e = '0;
        if (exp_q.size() != 0) e = exp_q[0];
        n_asserts++;
        assert (obs === e) else begin
            n_fail++;
            $error("[TB] FAIL %s outs observed=%h expected=%h", tag, obs, e);
        end
        n_asserts++;
        assert (err === err_exp) else begin
            n_fail++;
            $error("[TB] FAIL %s_err observed=%b expected=%b", tag, err, err_exp);
        end
        n_asserts++;
        assert (($countones(reg_out) + int'(Zlowout) + int'(Zhighout) <= 1) &&
                ($countones(reg_in) <= 1)) else begin
            n_fail++;
            $error("[TB] FAIL %s_onehot observed reg_out=%h zlo=%b zhi=%b reg_in=%h expected at most one driver",
                   tag, reg_out, Zlowout, Zhighout, reg_in);
        end
    endtask

    task automatic expectEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        @(negedge Clock);
        preload = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        preload = 1'b0;
        checkOutput("reset");
        expectEq("reset8", {busy8, done8, err8, reg_out8, reg_in8}, 64'd0);

        // Binary narrow shift: R1 = R3 << R2
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'b00011, 4'd1, 4'd3, 4'd2);
        checkOutput("bin_y");
        expectEq("bin_y_bus", {reg_out, Yin}, {16'h0008, 1'b1});
        idleStep(); checkOutput("bin_op");
        expectEq("bin_op_bus", {reg_out, Zin, op}, {16'h0004, 1'b1, 5'b00011});
        idleStep(); checkOutput("bin_lo");
        expectEq("bin_lo_load", {reg_in, Zlowout, done}, {16'h0002, 1'b1, 1'b1});
        idleStep(); checkOutput("bin_idle");
        expectEq("r1_result", {32'd0, rf[1]}, 64'd384);

        // Unary, then a start in the done cycle that must be dropped
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5'h07, 4'd4, 4'd0, 4'd7);
        checkOutput("un_op");
        expectEq("un_op_bus", {reg_out, Yin}, {16'h0080, 1'b0});
        idleStep(); checkOutput("un_lo");
        expectEq("un_lo_load", {reg_in, done}, {16'h0010, 1'b1});
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h01, 4'd2, 4'd3, 4'd4);
        checkOutput("done_start_ignored");
        expectEq("done_start_busy", {63'd0, busy}, 64'd0);

        // Wide: LO then HI, no register write
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'h0a, 4'd0, 4'd5, 4'd6);
        checkOutput("w_y");
        idleStep(); checkOutput("w_op");
        idleStep(); checkOutput("w_lo");
        expectEq("w_lo_strobes", {LOin, Zlowout, done, reg_in}, {1'b1, 1'b1, 1'b0, 16'h0000});
        idleStep(); checkOutput("w_hi");
        expectEq("w_hi_strobes", {Zhighout, HIin, done, reg_in}, {1'b1, 1'b1, 1'b1, 16'h0000});
        idleStep(); checkOutput("w_idle");

        // Clear in T_OP aborts; clear beats a simultaneous start; next start accepted
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h02, 4'd1, 4'd2, 4'd3);
        checkOutput("clr_y");
        idleStep(); checkOutput("clr_op");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'h02, 4'd1, 4'd2, 4'd3);
        checkOutput("clr_after");
        expectEq("clr_busy", {63'd0, busy}, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'h03, 4'd7, 4'd8, 4'd9);
        checkOutput("post_clr_accept");
        expectEq("post_clr_busy", {63'd0, busy}, 64'd1);
        repeat (3) begin idleStep(); checkOutput("post_clr_run"); end

        // Eight-register instance: out-of-range indices are rejected
        start8 = 1'b1; ra8 = 4'd1; rb8 = 4'd9; rc8 = 4'd2; wide8 = 1'b0; unary8 = 1'b0;
        idleStep(); start8 = 1'b0; checkOutput("e8_a");
        expectEq("err8_pulse", {62'd0, err8, busy8}, {62'd0, 1'b1, 1'b0});
        expectEq("err8_strobes", {reg_out8, reg_in8, Yin8, Zin8, Zlowout8, Zhighout8, LOin8, HIin8, op8},
                 64'd0);
        idleStep(); checkOutput("e8_b");
        expectEq("err8_single", {62'd0, err8, busy8}, 64'd0);
        start8 = 1'b1; ra8 = 4'd12; rb8 = 4'd1; rc8 = 4'd2; wide8 = 1'b1;
        idleStep(); start8 = 1'b0; checkOutput("w8_a");
        expectEq("w8_accept", {busy8, err8, Yin8, reg_out8}, {1'b1, 1'b0, 1'b1, 8'h02});
        idleStep(); idleStep(); idleStep(); checkOutput("w8_b");
        expectEq("w8_hi", {done8, HIin8, reg_in8}, {1'b1, 1'b1, 8'h00});
        idleStep(); checkOutput("w8_c");
        start8 = 1'b1; ra8 = 4'd8; rb8 = 4'd0; rc8 = 4'd0; wide8 = 1'b0;
        idleStep(); start8 = 1'b0; checkOutput("e8_c");
        expectEq("err8_ra", {62'd0, err8, busy8}, {62'd0, 1'b1, 1'b0});

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), OP_W'($urandom),
                          IDX_W'($urandom), IDX_W'($urandom), IDX_W'($urandom));
            checkOutput("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of general registers, one-hot select width.
REQ-002 SHALL have parameter IDX_W, default 4: register index width, ceil(log2(NUM_REGS)).
REQ-003 SHALL have parameter OP_W, default 5: ALU opcode width.
REQ-004 SHALL have port Clock  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  request to run one register-to-register ALU operation.
REQ-007 SHALL have port opcode  input  OP_W  ALU operation code, captured at accept.
REQ-008 SHALL have ports ra, rb, rc  input  IDX_W each  destination, first source, second source, captured at accept.
REQ-009 SHALL have port unary  input  1  operation uses rc only; skips Y load; captured at accept.
REQ-010 SHALL have port wide  input  1  64-bit result (mul/div); writes LO then HI instead of ra; captured at accept.
REQ-011 SHALL have port busy  output  1  sequence in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse in the final sequence cycle.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a rejected request.
REQ-014 SHALL have port op  output  OP_W  opcode to ALU; valid in T_OP only, else zero.
REQ-015 SHALL have ports reg_out, reg_in  output  NUM_REGS each  one-hot register bus-drive and load enables.
REQ-016 SHALL have ports Yin, Zin, Zlowout, Zhighout, LOin, HIin  output  1 each  datapath strobes.

Function
REQ-017 SHALL implement states IDLE, T_Y, T_OP, T_LO, T_HI; one state per clock cycle.
REQ-018 IDLE: start=1 with all indices < NUM_REGS -> capture inputs; next state T_OP if unary, else T_Y.
REQ-019 IDLE: start=1 with any index >= NUM_REGS (ra ignored when wide) -> err=1 next cycle, remain IDLE, no strobes.
REQ-020 T_Y: reg_out[rb]=1, Yin=1; next T_OP.
REQ-021 T_OP: reg_out[rc]=1, Zin=1, op=captured opcode; next T_LO.
REQ-022 T_LO: Zlowout=1; reg_in[ra]=1 if not wide, else LOin=1; next T_HI if wide, else IDLE.
REQ-023 T_HI: Zhighout=1, HIin=1; next IDLE.
REQ-024 busy=1 in T_Y, T_OP, T_LO, T_HI; 0 in IDLE.
REQ-025 done=1 only in final state (T_LO narrow, T_HI wide).
REQ-026 Latency accept to done: 3 cycles binary narrow, 2 unary narrow, +1 if wide.
REQ-027 start while busy=1 (including the done cycle) SHALL be ignored; no queuing.
REQ-028 At most one bus driver per cycle among reg_out bits, Zlowout, Zhighout; at most one reg_in bit high.
REQ-029 All outputs registered (decoded from state and captured fields); no combinational path from start to any strobe.
REQ-030 ra==rb==rc SHALL be legal and produce the same sequence.
REQ-031 Input changes after accept SHALL not affect the running sequence.

Reset
REQ-032 clear=1 at a rising edge -> IDLE; busy, done, err, op, reg_out, reg_in and all strobes 0 by the following cycle.
REQ-033 clear SHALL override start in the same cycle and abort any sequence mid-operation without further strobes.
REQ-034 After clear deasserts, next start SHALL be accepted normally.

Verification
REQ-035 start, opcode=5'b00011, rb=3, rc=2, ra=1 -> cycle1 reg_out=16'h0008,Yin; cycle2 reg_out=16'h0004,Zin,op=00011; cycle3 Zlowout,reg_in=16'h0002,done; with datapath R3=12,R2=5 -> R1=384.
REQ-036 unary=1, rc=7, ra=4 -> cycle1 T_OP reg_out=16'h0080; cycle2 reg_in=16'h0010,done; Yin never asserted.
REQ-037 wide=1, rb=5, rc=6 -> T_Y, T_OP, T_LO with LOin, T_HI with Zhighout,HIin,done; reg_in stays 0.
REQ-038 NUM_REGS=8, IDX_W=4, rb=9 -> err pulse one cycle, busy stays 0, no strobes.
REQ-039 clear asserted during T_OP -> next cycle all outputs 0, IDLE; start during done cycle ignored.
REQ-040 Every cycle: assert one-hot/zero-hot of reg_out, reg_in and single bus driver (REQ-028) across random starts.
